mesm6_vga_fill: RTL and testbench

- Fill engine and bus arbiter between the MESM-6 CPU bus and the 4-plane VGA adapter register port.
- CPU programs a job: start byte address, byte count, 8-bit pattern and plane mask. The engine then issues the PLANE, ADDRL and repeated DATA writes to the adapter on its own.
- While idle, CPU accesses to adapter registers pass straight through. While busy, they stall, so the engine's plane select and address latch are never disturbed mid-job.

---
 rtl/mesm6_vga_fill.sv | 191 +++++++++++++++++++
 tb/tb_mesm6_vga_fill.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_vga_fill.sv
// Fill engine and bus arbiter between the MESM-6 CPU bus and the 4-plane VGA adapter.
// Idle: CPU adapter accesses pass straight through; busy: the engine owns the adapter bus.
module mesm6_vga_fill #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  output logic              interrupt,
  input  logic [3:0]        s_addr,
  input  logic              s_rd,
  input  logic              s_wr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_done,
  output logic [2:0]        m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_PLANE = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]        state;
  logic              rel;
  logic [2:0]        plane;
  logic [ADDR_W-1:0] start_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  remain;
  logic [7:0]        pat_r;
  logic [3:0]        mask_r;
  logic              ie, aborted, irq_pending, abort_req, eng_done;
  logic [DATA_W-1:0] rdata_r, rd_mux;
  logic              busy, eng_sel, eng_act, wr_act, rd_act, ctrl_wr;
  logic [2:0]        next_p;
  logic              unused_bits;

  // Lowest enabled plane at or above 'from'; 4 means none left.
  function automatic logic [2:0] first_plane(input logic [3:0] m, input logic [2:0] from);
    first_plane = 3'd4;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (3'(i) >= from)) first_plane = 3'(i);
  endfunction

  assign busy        = (state != S_IDLE);
  assign eng_sel     = s_addr[3];
  assign eng_act     = eng_sel && (s_rd || s_wr) && !eng_done;
  assign wr_act      = eng_act && s_wr;
  assign rd_act      = eng_act && s_rd;
  assign ctrl_wr     = wr_act && (s_addr[2:0] == 3'd4);
  assign next_p      = first_plane(mask_r, plane);
  assign interrupt   = irq_pending && ie;
  assign unused_bits = ^s_wdata;

  always_comb begin
    rd_mux = '0;
    case (s_addr[2:0])
      3'd0:    rd_mux = DATA_W'(start_r);
      3'd1:    rd_mux = DATA_W'(remain);
      3'd2:    rd_mux = DATA_W'(pat_r);
      3'd3:    rd_mux = DATA_W'(mask_r);
      3'd5:    rd_mux = DATA_W'({ie, irq_pending, aborted, busy});
      default: rd_mux = '0;
    endcase
  end

  // While busy the engine owns m_*; CPU pass-through is held off until the job ends.
  always_comb begin
    m_addr  = '0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_wdata = '0;
    s_rdata = '0;
    s_done  = 1'b0;
    if (busy) begin
      case (state)
        S_PLANE: begin m_addr = 3'd6; m_wdata = DATA_W'(plane);   m_wr = !rel; end
        S_ADDR:  begin m_addr = 3'd7; m_wdata = DATA_W'(start_r); m_wr = !rel; end
        S_DATA:  begin m_addr = 3'd0; m_wdata = DATA_W'(pat_r);   m_wr = !rel; end
        default: ;
      endcase
    end
    if (eng_sel) begin
      s_done  = eng_done;
      s_rdata = rdata_r;
    end else if (!busy && reset) begin
      m_addr  = s_addr[2:0];
      m_rd    = s_rd;
      m_wr    = s_wr;
      m_wdata = s_wdata;
      s_rdata = m_rdata;
      s_done  = m_done;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rel         <= 1'b0;
      plane       <= '0;
      start_r     <= '0;
      count_r     <= '0;
      remain      <= '0;
      pat_r       <= '0;
      mask_r      <= '0;
      ie          <= 1'b0;
      aborted     <= 1'b0;
      irq_pending <= 1'b0;
      abort_req   <= 1'b0;
      eng_done    <= 1'b0;
      rdata_r     <= '0;
    end else begin
      eng_done <= eng_sel && (s_rd || s_wr);
      if (rd_act) rdata_r <= rd_mux;
      if (rd_act && (s_addr[2:0] == 3'd5)) irq_pending <= 1'b0;
      // Job parameters are frozen while busy, so they double as the working copies.
      if (wr_act && !busy) begin
        case (s_addr[2:0])
          3'd0:    start_r <= s_wdata[ADDR_W-1:0];
          3'd1:    begin count_r <= s_wdata[CNT_W-1:0]; remain <= s_wdata[CNT_W-1:0]; end
          3'd2:    pat_r   <= s_wdata[7:0];
          3'd3:    mask_r  <= s_wdata[3:0];
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        ie <= s_wdata[3];
        if (s_wdata[2]) irq_pending <= 1'b0;
        if (s_wdata[1] && busy) abort_req <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (ctrl_wr && s_wdata[0]) begin
            state       <= S_INIT;
            remain      <= count_r;
            plane       <= '0;
            rel         <= 1'b0;
            aborted     <= 1'b0;
            irq_pending <= 1'b0;
            abort_req   <= 1'b0;
          end
        end
        S_INIT: begin
          if (abort_req || (count_r == '0) || (next_p == 3'd4)) begin
            state <= S_FIN;
          end else if (!m_done) begin
            plane <= next_p;
            state <= S_PLANE;
          end
        end
        S_PLANE, S_ADDR, S_DATA: begin
          // REQ holds the strobe until done; REL waits for done to fall before the next write.
          if (!rel) begin
            if (m_done) begin
              rel <= 1'b1;
              if (state == S_DATA) remain <= remain - CNT_W'(1);
            end
          end else if (!m_done) begin
            rel <= 1'b0;
            if (abort_req) begin
              state <= S_FIN;
            end else if (state == S_PLANE) begin
              state <= S_ADDR;
            end else if (state == S_ADDR) begin
              state <= S_DATA;
            end else if (remain == '0) begin
              remain <= count_r;
              plane  <= plane + 3'd1;
              state  <= S_INIT;
            end
          end
        end
        S_FIN: begin
          irq_pending <= 1'b1;
          aborted     <= abort_req;
          abort_req   <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesm6_vga_fill.sv
// Bench for mesm6_vga_fill: registered adapter model with plane memory, expected-write
// queue built from job parameters, and directed CPU register sequences.
module tb_mesm6_vga_fill;
  localparam int DATA_W = 48;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              interrupt;
  logic [3:0]        s_addr = '0;
  logic              s_rd = 1'b0;
  logic              s_wr = 1'b0;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [DATA_W-1:0] s_rdata;
  logic              s_done;
  logic [2:0]        m_addr;
  logic              m_rd;
  logic              m_wr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_done = 1'b0;

  mesm6_vga_fill #(.DATA_W(48), .ADDR_W(14), .CNT_W(14)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .s_addr(s_addr), .s_rd(s_rd), .s_wr(s_wr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_done(s_done),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Registered adapter slave
  always @(posedge clk) m_done <= m_rd | m_wr;
  assign m_rdata = 48'h1234_5678_9A00 | {45'b0, m_addr};

  typedef struct packed { logic [2:0] a; logic [47:0] d; } wr_t;
  wr_t  exp_q[$];
  wr_t  e_w;
  int   checks = 0, errors = 0, n_writes = 0, data_writes = 0;
  int   last_act = 0;
  logic prev_req = 1'b0;
  logic [7:0]  mem [0:3][0:16383];
  logic [1:0]  a_plane = '0;
  logic [13:0] a_ptr = '0;

  // Compare process: every adapter write against the expected queue, plus strobe integrity.
  always @(negedge clk) begin
    if (!reset) begin
      prev_req = 1'b0;
    end else begin
      if (prev_req) begin
        checks++;
        if (!m_wr) begin
          errors++;
          $display("FAIL strobe_truncated m_wr=%0d required=1", m_wr);
        end
      end
      prev_req = m_wr && !m_done;
      if (m_wr && !m_done) begin
        n_writes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL adapter_write unexpected addr=%0d data=%h required=none", m_addr, m_wdata);
        end else begin
          e_w = exp_q.pop_front();
          if (m_addr !== e_w.a || m_wdata !== e_w.d) begin
            errors++;
            $display("FAIL adapter_write addr=%0d data=%h required addr=%0d data=%h",
                     m_addr, m_wdata, e_w.a, e_w.d);
          end
        end
        case (m_addr)
          3'd6: a_plane = m_wdata[1:0];
          3'd7: a_ptr = m_wdata[13:0];
          3'd0: begin
            mem[a_plane][a_ptr] = m_wdata[7:0];
            a_ptr = a_ptr + 14'd1;
            data_writes++;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=no_event required=event", name);
  endtask

  task automatic push(input logic [2:0] a, input logic [47:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Expected adapter write stream for one complete job.
  task automatic model_job(input int start, input int count, input logic [7:0] pat, input logic [3:0] mask);
    if (count == 0) return;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin
        push(3'd6, 48'(p));
        push(3'd7, 48'(start));
        for (int k = 0; k < count; k++) push(3'd0, {40'b0, pat});
      end
    end
  endtask

  task automatic cpu_xfer(input logic wr, input logic [3:0] a, input logic [47:0] d,
                          input int bound, output logic [47:0] rd);
    logic ok;
    @(negedge clk);
    #1;
    s_addr = a; s_wdata = d; s_wr = wr; s_rd = !wr;
    last_act = cyc + 1;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (s_done) begin ok = 1'b1; rd = s_rdata; break; end
    end
    #1;
    s_wr = 1'b0; s_rd = 1'b0;
    if (!ok) begin
      timeout("s_done_rise");
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (!s_done) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("s_done_fall");
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [47:0] d);
    logic [47:0] dummy;
    cpu_xfer(1'b1, a, d, 20, dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [47:0] v);
    cpu_xfer(1'b0, a, '0, 20, v);
  endtask

  task automatic prog(input int start, input int count, input logic [7:0] pat, input logic [3:0] mask);
    wr(4'h8, 48'(start));
    wr(4'h9, 48'(count));
    wr(4'hA, {40'b0, pat});
    wr(4'hB, {44'b0, mask});
  endtask

  task automatic wait_irq(input int bound, output int t);
    logic ok;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (interrupt) begin ok = 1'b1; t = cyc; break; end
    end
    if (!ok) timeout("interrupt");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] v;
    logic [47:0] dummy;
    int t1, nw, dw0, ok;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 16384; i++) mem[p][i] = 8'h00;

    // Reset state, including a pass-through strobe that must stay blocked
    repeat (3) @(negedge clk);
    #1;
    s_addr = 4'h7; s_wdata = 48'h55; s_wr = 1'b1;
    @(negedge clk);
    check("rst_interrupt", 64'(interrupt), 0);
    check("rst_m_wr", 64'(m_wr), 0);
    check("rst_m_wdata", 64'(m_wdata), 0);
    check("rst_m_addr", 64'(m_addr), 0);
    check("rst_s_done", 64'(s_done), 0);
    #1;
    s_wr = 1'b0; s_addr = 4'h0; s_wdata = '0;
    @(negedge clk);
    #1 reset = 1'b1;

    rd(4'h2, v);
    check("pt_read_idle", 64'(v), 64'h1234_5678_9A02);

    // Single plane job and its timing
    prog(0, 3, 8'hA5, 4'b0010);
    model_job(0, 3, 8'hA5, 4'b0010);
    check("model_len", 64'(exp_q.size()), 5);
    check("model_first", 64'({exp_q[0].a, exp_q[0].d}), 64'({3'd6, 48'd1}));
    wr(4'hC, 48'h9);
    wait_irq(200, t1);
    check_range("irq_latency", t1 - last_act, 22, 24);
    check("job1_queue_drained", 64'(exp_q.size()), 0);
    rd(4'hD, v);
    check("job1_status", 64'(v), 64'hC);
    @(negedge clk);
    check("job1_irq_after_status", 64'(interrupt), 0);
    check("job1_mem0", 64'(mem[1][0]), 64'hA5);
    check("job1_mem2", 64'(mem[1][2]), 64'hA5);
    check("job1_mem3", 64'(mem[1][3]), 64'h00);

    // Two planes, 0 and 3
    prog(100, 2, 8'h5A, 4'b1001);
    model_job(100, 2, 8'h5A, 4'b1001);
    wr(4'hC, 48'h9);
    wait_irq(400, t1);
    check("job2_queue_drained", 64'(exp_q.size()), 0);
    rd(4'hD, v);
    check("job2_status", 64'(v), 64'hC);
    check("job2_p0_100", 64'(mem[0][100]), 64'h5A);
    check("job2_p0_101", 64'(mem[0][101]), 64'h5A);
    check("job2_p0_102", 64'(mem[0][102]), 64'h00);
    check("job2_p3_101", 64'(mem[3][101]), 64'h5A);
    check("job2_p1_untouched", 64'(mem[1][100]), 64'h00);
    check("job2_p2_untouched", 64'(mem[2][100]), 64'h00);

    // Pass-through write stalls behind the job; busy-time param write ignored
    prog(200, 3, 8'h3C, 4'b0100);
    model_job(200, 3, 8'h3C, 4'b0100);
    wr(4'hC, 48'h9);
    wr(4'hA, 48'hFF);
    push(3'd7, 48'd500);
    cpu_xfer(1'b1, 4'h7, 48'd500, 400, dummy);
    check("pt_after_job_irq", 64'(interrupt), 1);
    check("pt_queue_drained", 64'(exp_q.size()), 0);
    rd(4'hA, v);
    check("busy_pattern_ignored", 64'(v), 64'h3C);
    rd(4'hD, v);
    check("job3_status", 64'(v), 64'hC);
    check("job3_p2_200", 64'(mem[2][200]), 64'h3C);
    check("job3_p2_202", 64'(mem[2][202]), 64'h3C);
    check("job3_p2_203", 64'(mem[2][203]), 64'h00);

    // COUNT=0 and MASK=0 complete with no adapter traffic
    prog(0, 0, 8'h11, 4'hF);
    nw = n_writes;
    wr(4'hC, 48'h9);
    wait_irq(20, t1);
    check_range("zero_count_latency", t1 - last_act, 1, 3);
    check("zero_count_writes", 64'(n_writes - nw), 0);
    wr(4'hC, 48'hC);
    @(negedge clk);
    check("irq_clear", 64'(interrupt), 0);
    prog(0, 5, 8'h11, 4'h0);
    nw = n_writes;
    wr(4'hC, 48'h9);
    wait_irq(20, t1);
    check_range("zero_mask_latency", t1 - last_act, 1, 3);
    check("zero_mask_writes", 64'(n_writes - nw), 0);
    rd(4'hD, v);
    check("zero_mask_status", 64'(v), 64'hC);

    // Start and abort together while idle: start wins
    prog(300, 1, 8'h66, 4'b0001);
    model_job(300, 1, 8'h66, 4'b0001);
    wr(4'hC, 48'hB);
    wait_irq(100, t1);
    check("start_abort_queue", 64'(exp_q.size()), 0);
    rd(4'hD, v);
    check("start_abort_status", 64'(v), 64'hC);

    // Abort a long job after 100 data writes
    prog(0, 9600, 8'h5A, 4'hF);
    model_job(0, 9600, 8'h5A, 4'hF);
    dw0 = data_writes;
    wr(4'hC, 48'h9);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (data_writes - dw0 >= 100) begin ok = 1; break; end
    end
    if (ok == 0) timeout("abort_100_writes");
    wr(4'hC, 48'hA);
    wait_irq(100, t1);
    rd(4'hD, v);
    check("abort_status", 64'(v), 64'hE);
    check_range("abort_data_writes", data_writes - dw0, 100, 101);
    rd(4'h9, v);
    check("abort_count_remaining", 64'(v), 64'(9600 - (data_writes - dw0)));
    exp_q.delete();

    // Reset asserted mid-DATA with the strobe high
    prog(50, 5, 8'h77, 4'b0001);
    model_job(50, 5, 8'h77, 4'b0001);
    wr(4'hC, 48'h9);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_wr && m_addr == 3'd0) begin ok = 1; break; end
    end
    if (ok == 0) timeout("mid_data_strobe");
    #1 reset = 1'b0;
    #1;
    check("mid_reset_m_wr", 64'(m_wr), 0);
    check("mid_reset_interrupt", 64'(interrupt), 0);
    check("mid_reset_m_wdata", 64'(m_wdata), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    rd(4'h8, v);
    check("post_reset_start", 64'(v), 0);
    rd(4'h9, v);
    check("post_reset_count", 64'(v), 0);
    rd(4'hA, v);
    check("post_reset_pattern", 64'(v), 0);
    rd(4'hB, v);
    check("post_reset_mask", 64'(v), 0);
    rd(4'hD, v);
    check("post_reset_status", 64'(v), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
